// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter slice.
// Contents:
//   OP_*      - 3-bit Calculator opcodes
//   state_e   - arbiter FSM states (IDLE / EXEC / RESP)
//   req_id_t  - requester identifier (0 or 1)
package calc_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MULT = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/calculator.sv
// Combinational Calculator datapath.
// Ports:
//   a, b : 4-bit operands
//   op   : 3-bit opcode (see calc_pkg OP_*)
//   out  : 8-bit result
// Divide by zero yields 0 here; callers that care must trap it themselves.
module calculator
  import calc_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [7:0] out
);

  logic [4:0] sum;
  logic [4:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit 4 of the 5-bit difference is the borrow; it fills the upper nibble.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    out = 8'h00;
    case (op)
      OP_AND:  out = {4'h0, a & b};
      OP_OR:   out = {4'h0, a | b};
      OP_NOT:  out = {4'hF, ~a};
      OP_XOR:  out = {4'h0, a ^ b};
      OP_ADD:  out = {3'b000, sum};
      OP_SUB:  out = {{4{diff[4]}}, diff[3:0]};
      OP_MULT: out = {4'h0, a} * {4'h0, b};
      OP_DIV:  out = (b == 4'd0) ? 8'h00 : {4'h0, a / b};
      default: out = 8'h00;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin grant, purely combinational.
// Ports:
//   valid0, valid1 : request valids
//   last_grant     : requester served most recently
//   gnt_valid      : some requester is granted
//   gnt_id         : granted requester
module rr_arb2
  import calc_pkg::*;
(
  input  logic    valid0,
  input  logic    valid1,
  input  req_id_t last_grant,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    gnt_valid = valid0 | valid1;
    gnt_id    = 1'b0;
    if (valid0 && valid1) begin
      gnt_id = ~last_grant;
    end else if (valid1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one Calculator between two requesters.
// Round-robin grant in IDLE, one EXEC cycle on latched operands, then a
// registered result held in RESP until the granted requester takes it.
// Divide by zero returns ERR_VALUE with resp_err set and bumps a saturating
// error counter.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   reqN_valid/ready, reqN_a/b/op    : request channels (N = 0, 1)
//   respN_valid/ready                : response channels (N = 0, 1)
//   resp_data, resp_err              : shared registered result
//   busy                             : FSM not in IDLE
//   err_cnt                          : saturating divide-by-zero count
module calc_arbiter
  import calc_pkg::*;
#(
  parameter logic [7:0] ERR_VALUE = 8'hFF,
  parameter int         ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [3:0]           req0_a,
  input  logic [3:0]           req0_b,
  input  logic [2:0]           req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [3:0]           req1_a,
  input  logic [3:0]           req1_b,
  input  logic [2:0]           req1_op,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [7:0]           resp_data,
  output logic                 resp_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e               state_q, state_d;
  req_id_t              last_grant_q, last_grant_d;
  req_id_t              grant_id_q, grant_id_d;
  logic [3:0]           a_q, a_d;
  logic [3:0]           b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [7:0]           resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic    gnt_valid;
  req_id_t gnt_id;
  logic    resp_taken;
  logic    div_by_zero;
  logic [7:0] calc_out;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  calculator u_calc (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .out (calc_out)
  );

  assign div_by_zero = (op_q == OP_DIV) && (b_q == 4'd0);
  assign resp_taken  = grant_id_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    err_cnt_d    = err_cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp0_valid  = 1'b0;
    resp1_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is combinational from valid, so gate it with rst_n to keep it
        // low while reset is held.
        req0_ready = rst_n && gnt_valid && (gnt_id == 1'b0);
        req1_ready = rst_n && gnt_valid && (gnt_id == 1'b1);
        if (gnt_valid) begin
          grant_id_d = gnt_id;
          a_d        = gnt_id ? req1_a  : req0_a;
          b_d        = gnt_id ? req1_b  : req0_b;
          op_d       = gnt_id ? req1_op : req0_op;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (div_by_zero) begin
          resp_data_d = ERR_VALUE;
          resp_err_d  = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end else begin
          resp_data_d = calc_out;
          resp_err_d  = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        resp0_valid = (grant_id_q == 1'b0);
        resp1_valid = (grant_id_q == 1'b1);
        if (resp_taken) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the operand registers are few flops, not a memory, so they are reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
module tb_calc_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic       resp0_valid, resp1_valid;
  logic       resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       busy;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference state: who was served last, and the expected error count.
  bit last_served = 1'b1;
  int exp_err_cnt = 0;

  calc_arbiter #(.ERR_VALUE(8'hFF), .ERR_CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Calculator semantics written as plain integer arithmetic.
  function automatic logic [7:0] ref_calc(input int a, input int b, input int op);
    case (op)
      0: return 8'(a & b);
      1: return 8'(a | b);
      2: return 8'(240 + (15 - a));
      3: return 8'(a ^ b);
      4: return 8'(a + b);
      5: return 8'((a - b) & 255);
      6: return 8'(a * b);
      default: return (b == 0) ? 8'hFF : 8'(a / b);
    endcase
  endfunction

  function automatic bit pick(input bit v0, input bit v1);
    if (v0 && v1) return !last_served;
    return v1;
  endfunction

  // One complete transaction for requester id whose inputs are already driven.
  // drop[n] releases requester n's valid (and scrambles its operands) once
  // the operation is in flight.
  task automatic expect_txn(input bit id, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, input int hold, input bit [1:0] drop);
    logic [7:0] exp_data;
    bit         exp_err;
    int         waited;
    exp_data = ref_calc(int'(a), int'(b), int'(op));
    exp_err  = (op == 3'd7) && (b == 4'd0);
    #1;
    waited = 0;
    while (!(id ? req1_ready : req0_ready) && waited < 20) begin
      tick();
      #1;
      waited++;
    end
    check("req_ready", id ? req1_ready : req0_ready, 1);
    check("other_ready", id ? req0_ready : req1_ready, 0);
    tick();
    if (drop[0]) begin
      req0_valid = 1'b0; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
    end
    if (drop[1]) begin
      req1_valid = 1'b0; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
    end
    #1;
    check("exec_busy", busy, 1);
    check("exec_resp_valid", {resp1_valid, resp0_valid}, 0);
    check("exec_req_ready", {req1_ready, req0_ready}, 0);
    tick();
    #1;
    if (exp_err && exp_err_cnt < 255) exp_err_cnt++;
    check("resp_valid", {resp1_valid, resp0_valid}, id ? 2'b10 : 2'b01);
    check("resp_data", resp_data, exp_data);
    check("resp_err", resp_err, exp_err);
    check("err_cnt", err_cnt, exp_err_cnt);
    check("resp_busy", busy, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      #1;
      check("hold_valid", {resp1_valid, resp0_valid}, id ? 2'b10 : 2'b01);
      check("hold_data", resp_data, exp_data);
      check("hold_err", resp_err, exp_err);
      check("hold_req_ready", {req1_ready, req0_ready}, 0);
    end
    if (id) resp1_ready = 1'b1;
    else    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    #1;
    check("done_valid", {resp1_valid, resp0_valid}, 0);
    check("done_busy", busy, 0);
    last_served = id;
  endtask

  initial begin
    // Reset state, including ready held low while a valid is present.
    req0_valid = 1'b1;
    tick();
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Tie right after reset: requester 0 first, then strict alternation.
    req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd5;  req0_op = 3'd5;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15; req1_op = 3'd6;
    check("tie_pick_model", pick(1'b1, 1'b1), 0);
    expect_txn(1'b0, 4'd3, 4'd5, 3'd5, 0, 2'b00);
    expect_txn(1'b1, 4'd15, 4'd15, 3'd6, 0, 2'b00);
    expect_txn(1'b0, 4'd3, 4'd5, 3'd5, 0, 2'b00);
    expect_txn(1'b1, 4'd15, 4'd15, 3'd6, 0, 2'b11);

    // Single requester ADD.
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd9; req0_op = 3'd4;
    expect_txn(1'b0, 4'd7, 4'd9, 3'd4, 0, 2'b01);

    // Divide by zero, then a normal divide.
    req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd0; req1_op = 3'd7;
    expect_txn(1'b1, 4'd9, 4'd0, 3'd7, 0, 2'b10);
    req1_valid = 1'b1; req1_a = 4'd13; req1_b = 4'd4; req1_op = 3'd7;
    expect_txn(1'b1, 4'd13, 4'd4, 3'd7, 0, 2'b10);

    // Response stall with requester 1 waiting the whole time.
    req0_valid = 1'b1; req0_a = 4'd10; req0_b = 4'd6;  req0_op = 3'd3;
    req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd10; req1_op = 3'd0;
    expect_txn(1'b0, 4'd10, 4'd6, 3'd3, 5, 2'b01);
    expect_txn(1'b1, 4'd12, 4'd10, 3'd0, 0, 2'b10);

    // Reset pulse during EXEC aborts the operation.
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_op = 3'd4;
    #1;
    check("abort_accept", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    check("abort_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_resp_valid", {resp1_valid, resp0_valid}, 0);
    check("abort_resp_data", resp_data, 0);
    check("abort_err_cnt", err_cnt, 0);
    last_served = 1'b1;
    exp_err_cnt = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("post_abort_valid", {resp1_valid, resp0_valid, busy}, 0);
    end
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd0; req1_op = 3'd2;
    expect_txn(1'b1, 4'd5, 4'd0, 3'd2, 0, 2'b10);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      bit v0, v1, id;
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
      if ($urandom_range(0, 3) == 0) req0_b = 4'd0;
      if ($urandom_range(0, 3) == 0) req1_b = 4'd0;
      req0_valid = v0;
      req1_valid = v1;
      id = pick(v0, v1);
      if (id) expect_txn(1'b1, req1_a, req1_b, req1_op, $urandom_range(0, 2), 2'b11);
      else    expect_txn(1'b0, req0_a, req0_b, req0_op, $urandom_range(0, 2), 2'b11);
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) begin
      req0_valid = 1'b1; req0_a = 4'($urandom); req0_b = 4'd0; req0_op = 3'd7;
      expect_txn(1'b0, req0_a, 4'd0, 3'd7, 0, 2'b01);
    end
    check("sat_final", err_cnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
Shares one instance of the team's combinational Calculator datapath (4-bit a/b, 3-bit op, 8-bit out) between two requesters. A round-robin grant selects one request at a time, and a 3-state FSM latches its operands, executes, and returns a registered result to the granted requester over a valid/ready response channel. The block also traps divide-by-zero and keeps a saturating error count. It sits between the input-capture logic (switch/button front ends) and the display path.

Parameters:
ERR_VALUE, 8'hFF, result returned for divide-by-zero
ERR_CNT_W, 8, width of error counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  4  operand A
req0_b  in  4  operand B
req0_op  in  3  opcode (AND 000, OR 001, NOT 010, XOR 011, ADD 100, SUB 101, MULT 110, DIV 111)
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0
resp0_valid  out  1  result for requester 0 available
resp0_ready  in  1  requester 0 consumes result
resp1_valid, resp1_ready  same for requester 1
resp_data  out  8  result, shared by both response channels
resp_err  out  1  result is a divide-by-zero trap
busy  out  1  FSM not in IDLE
err_cnt  out  ERR_CNT_W  saturating divide-by-zero count

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, last_grant=1;
  - all ready/valid outputs 0, resp_data=0, resp_err=0, busy=0, err_cnt=0.
  - The latched operands are cleared.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection:
    - If only one valid is high, grant that requester.
    - If both are high, grant the requester other than last_grant.
    - If neither is high, stay in IDLE.
  - reqN_ready=1 combinationally only for the granted N, and only while in IDLE.
  - When the handshake occurs, latch a/b/op and grant_id, then go to EXEC.
- EXEC (one cycle):
  - The latched operands drive the Calculator.
  - Capture resp_data: if op==DIV and b==0, resp_data=ERR_VALUE, resp_err=1, and err_cnt increments (saturating at all-ones).
  - Otherwise resp_data=Calculator out and resp_err=0.
  - Go to RESP.
- RESP:
  - resp<grant_id>_valid=1; the other response valid stays 0.
  - resp_data and resp_err are held stable until resp<grant_id>_ready=1.
  - On that handshake: last_grant<=grant_id, state<=IDLE.
  - No new request is accepted while in RESP.
- Latency: request handshake in cycle T, resp_valid high in cycle T+2. If ready is already high, the response handshake occurs in T+2. Minimum issue interval is 3 cycles per operation.
- Arithmetic follows Calculator semantics:
  - ADD: zero-extended 5-bit sum.
  - SUB: 4-bit difference with upper nibble = sign fill from carry (3-5 → 8'hFE).
  - MULT: full 8-bit product.
  - NOT: upper nibble 1s.
  - DIV: a/b truncated, zero-extended.
- resp_data is registered only; there is no combinational path from req inputs to resp outputs.
- A requester may drop valid before it is granted; no state changes.
- Operands that change after acceptance are ignored.
- Reset asserted mid-EXEC or mid-RESP aborts the operation, and no response is produced. After release, the block behaves as if freshly reset; requester 0 wins the first tie.
- busy=1 in EXEC and RESP.

Decomposition:
- Shared package calc_pkg:
  - opcode localparams (OP_AND..OP_DIV);
  - FSM state enum (IDLE/EXEC/RESP);
  - requester-ID type (1 bit).
- Sub-module rr_arb2: 2-input round-robin grant from valids plus last_grant, purely combinational.
- The Calculator is instantiated unmodified inside calc_arbiter.

Test Plan:
- req0 ADD a=7 b=9 alone → req0_ready high at T; resp0_valid at T+2 with resp_data=8'h10, resp_err=0; busy high for 2 cycles.
- After reset, both valid in the same cycle (req0 SUB 3,5; req1 MULT 15,15):
  - req0 is served first with 8'hFE, then req1 with 8'hE1.
  - Keeping both valid continuously, grants alternate 0,1,0,1.
- req1 DIV a=9 b=0 → resp1_valid with resp_data=8'hFF, resp_err=1, err_cnt=1. Then req1 DIV 13,4 → 8'h03, resp_err=0, err_cnt stays 1.
- resp0_ready held low 5 cycles in RESP → resp0_valid, resp_data and resp_err stable. req1_valid is high throughout but req1_ready stays 0 until the resp0 handshake completes.
- rst_n pulsed low during EXEC → outputs are 0 in the same cycle (async), and no resp_valid appears. After release, req1 NOT a=5 → 8'hFA returned normally.
- Saturation: 260 divide-by-zero ops → err_cnt stops at 8'hFF.
